// File: rtl/maxpool_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_stage_pkg
// Purpose  : Shared defaults and helpers for the max-pool stage and its
//            line buffer.
// Contents : c_DEF_* default parameter values, idx_width() index sizing.
// Revision : 1.0 - initial release
// ============================================================================
package maxpool_stage_pkg;

  localparam int c_DEF_DATA_WIDTH = 16;
  localparam int c_DEF_IN_SIZE    = 8;
  localparam int c_DEF_MAXPOOL    = 1;

  // Width of an index able to address n entries; never narrower than 1 bit
  // so that degenerate sizes (n = 1) still yield a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_line_buf
// Purpose  : Row buffer holding one horizontal pair-maximum per output column
//            between the even and odd input rows of a pooling window.
// Ports    : i_clk    - clock
//            i_we     - write enable (even rows)
//            i_waddr  - write index
//            i_wdata  - value to store
//            i_raddr  - read index
//            o_rdata  - combinational read data (odd rows)
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_line_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // No reset: every entry is written on an even row before the odd row
  // that reads it, so its power-up contents are never observed.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/maxpool_stage.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_stage
// Purpose  : 2x2 stride-2 signed max-pool over a raster stream of
//            IN_SIZE x IN_SIZE samples, or a one-cycle registered bypass.
// Ports    : i_clk   - clock, rising edge
//            i_rst   - synchronous active-low reset
//            i_go    - frame start, clears the position counters
//            i_valid - i_data qualifier (no backpressure)
//            i_data  - signed input sample
//            o_valid - single-cycle strobe per output sample
//            o_data  - signed pooled (or bypassed) sample
//            o_done  - one-cycle pulse after the last frame sample
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_stage
  import maxpool_stage_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int IN_SIZE    = c_DEF_IN_SIZE,
  parameter int MAXPOOL    = c_DEF_MAXPOOL
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_go,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_done
);

  localparam int POOL_SIZE = IN_SIZE / 2;
  localparam int CW        = idx_width(IN_SIZE);
  localparam int AW        = idx_width(POOL_SIZE);

  localparam logic [CW-1:0] c_LAST = CW'(IN_SIZE - 1);
  // Columns/rows at or beyond this index belong to no complete window
  // (only reachable for odd IN_SIZE).
  localparam logic [CW:0]   c_SPAN = (CW + 1)'(2 * POOL_SIZE);

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // --------------------------------------------------------------------------
  // Position tracking
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic          r_done;
  logic [CW-1:0] w_col;
  logic [CW-1:0] w_row;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_acc;

  // i_go takes effect in its own cycle, so a sample arriving with it is
  // treated as position (0,0).
  assign w_col      = i_go ? '0 : r_col;
  assign w_row      = i_go ? '0 : r_row;
  assign w_col_last = (w_col == c_LAST);
  assign w_row_last = (w_row == c_LAST);
  assign w_acc      = i_valid & i_rst;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= i_valid & w_col_last & w_row_last;
      if (i_valid) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end else if (i_go) begin
        r_col <= '0;
        r_row <= '0;
      end
    end
  end

  assign o_done = r_done;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  generate
    if (MAXPOOL != 0) begin : g_pool
      logic signed [DATA_WIDTH-1:0] r_hold;
      logic signed [DATA_WIDTH-1:0] w_x;
      logic signed [DATA_WIDTH-1:0] w_pm;
      logic signed [DATA_WIDTH-1:0] w_lb_rd;
      logic        [AW-1:0]         w_lb_addr;
      logic                         w_col_odd;
      logic                         w_row_odd;
      logic                         w_col_in;
      logic                         w_row_in;
      logic                         w_lb_we;
      logic                         w_fire;
      logic                         r_valid;
      logic        [DATA_WIDTH-1:0] r_data;

      assign w_x       = $signed(i_data);
      assign w_col_odd = w_col[0];
      assign w_row_odd = w_row[0];
      assign w_col_in  = ({1'b0, w_col} < c_SPAN);
      assign w_row_in  = ({1'b0, w_row} < c_SPAN);
      assign w_lb_addr = AW'(w_col >> 1);

      // Horizontal pair maximum, formed on the odd column of each pair.
      assign w_pm    = smax(r_hold, w_x);
      assign w_lb_we = w_acc & w_col_odd & ~w_row_odd;
      // An odd column is always inside the span, so only the row needs
      // the bound check.
      assign w_fire  = w_acc & w_col_odd & w_row_odd & w_row_in;

      always_ff @(posedge i_clk) begin
        if (w_acc && !w_col_odd && w_col_in) begin
          r_hold <= w_x;
        end
      end

      maxpool_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (POOL_SIZE),
        .ADDR_WIDTH (AW)
      ) u_line_buf (
        .i_clk   (i_clk),
        .i_we    (w_lb_we),
        .i_waddr (w_lb_addr),
        .i_wdata (w_pm),
        .i_raddr (w_lb_addr),
        .o_rdata (w_lb_rd)
      );

      always_ff @(posedge i_clk) begin
        if (!i_rst) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else begin
          r_valid <= w_fire;
          if (w_fire) begin
            r_data <= smax(w_lb_rd, w_pm);
          end
        end
      end

      assign o_valid = r_valid;
      assign o_data  = r_data;
    end else begin : g_bypass
      logic                  r_valid;
      logic [DATA_WIDTH-1:0] r_data;

      always_ff @(posedge i_clk) begin
        if (!i_rst) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else begin
          r_valid <= i_valid;
          r_data  <= i_data;
        end
      end

      assign o_valid = r_valid;
      assign o_data  = r_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_maxpool_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_stage
// Purpose  : Scoreboard bench for maxpool_stage. Three instances share one
//            input stream: 4x4 pool, 5x5 pool and 4x4 bypass.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_stage;

  localparam int DW = 16;
  localparam int NI = 3;

  typedef struct {
    int                    stamp;
    logic                  v;
    logic signed [DW-1:0]  d;
    logic                  dn;
  } exp_t;

  logic                   clk   = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   go    = 1'b0;
  logic                   valid = 1'b0;
  logic [DW-1:0]          data  = '0;
  logic [NI-1:0]          ov;
  logic [NI-1:0]          odn;
  logic [NI-1:0][DW-1:0]  od;

  int   insz [NI] = '{4, 5, 4};
  int   pl   [NI] = '{1, 1, 0};
  int   mrow [NI];
  int   mcol [NI];
  int   frm  [NI][5][5];
  exp_t q    [NI][$];

  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  maxpool_stage #(.DATA_WIDTH(DW), .IN_SIZE(4), .MAXPOOL(1)) dut_p4 (
    .i_clk(clk), .i_rst(rst_n), .i_go(go), .i_valid(valid), .i_data(data),
    .o_valid(ov[0]), .o_data(od[0]), .o_done(odn[0]));

  maxpool_stage #(.DATA_WIDTH(DW), .IN_SIZE(5), .MAXPOOL(1)) dut_p5 (
    .i_clk(clk), .i_rst(rst_n), .i_go(go), .i_valid(valid), .i_data(data),
    .o_valid(ov[1]), .o_data(od[1]), .o_done(odn[1]));

  maxpool_stage #(.DATA_WIDTH(DW), .IN_SIZE(4), .MAXPOOL(0)) dut_byp (
    .i_clk(clk), .i_rst(rst_n), .i_go(go), .i_valid(valid), .i_data(data),
    .o_valid(ov[2]), .o_data(od[2]), .o_done(odn[2]));

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference: store the frame as a 2-D picture; whenever a sample completes
  // a 2x2 window, the expected output is the maximum of those four pixels.
  task automatic model_accept(input int k, input int x);
    int   n, r, c, p, m;
    exp_t e;
    n = insz[k];
    r = mrow[k];
    c = mcol[k];
    p = n / 2;
    frm[k][r][c] = x;
    e.stamp = cyc;
    e.v     = 1'b0;
    e.d     = '0;
    e.dn    = (r == n - 1) && (c == n - 1);
    if (pl[k] == 0) begin
      e.v = 1'b1;
      e.d = x[DW-1:0];
    end else if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * p) && (c < 2 * p)) begin
      m = imax(imax(frm[k][r-1][c-1], frm[k][r-1][c]),
               imax(frm[k][r][c-1], x));
      e.v = 1'b1;
      e.d = m[DW-1:0];
    end
    if (e.v || e.dn) q[k].push_back(e);
    if (c == n - 1) begin
      mcol[k] = 0;
      mrow[k] = (r == n - 1) ? 0 : r + 1;
    end else begin
      mcol[k] = c + 1;
    end
  endtask

  // Model process: observes the same inputs the DUTs sample at each edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      for (int k = 0; k < NI; k++) begin
        if (!rst_n) begin
          mrow[k] = 0;
          mcol[k] = 0;
        end else begin
          if (go) begin
            mrow[k] = 0;
            mcol[k] = 0;
          end
          if (valid) model_accept(k, int'($signed(data)));
        end
      end
    end
  end

  // Monitor: every output event must match the oldest expectation, in the
  // cycle right after its accepting edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int k = 0; k < NI; k++) begin
          if (ov[k] || odn[k]) begin
            n_vec = n_vec + 1;
            if (q[k].size() == 0) begin
              n_err = n_err + 1;
              $display("FAIL out%0d unexpected at cyc %0d: got v=%0b d=%0d done=%0b, want no output",
                       k, cyc, ov[k], $signed(od[k]), odn[k]);
            end else begin
              e = q[k].pop_front();
              if (e.stamp != cyc || e.v != ov[k] || e.dn != odn[k] ||
                  (e.v && e.d != $signed(od[k]))) begin
                n_err = n_err + 1;
                $display("FAIL out%0d at cyc %0d: got v=%0b d=%0d done=%0b, want v=%0b d=%0d done=%0b at cyc %0d",
                         k, cyc, ov[k], $signed(od[k]), odn[k], e.v, e.d, e.dn, e.stamp);
              end
            end
          end else if (q[k].size() != 0 && q[k][0].stamp <= cyc) begin
            e = q[k].pop_front();
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL out%0d missing at cyc %0d: got no output, want v=%0b d=%0d done=%0b",
                     k, cyc, e.v, e.d, e.dn);
          end
        end
      end
    end
  end

  task automatic step(input bit r, input bit g, input bit v, input int x);
    @(negedge clk);
    rst_n = r;
    go    = g;
    valid = v;
    data  = x[DW-1:0];
  endtask

  task automatic send(input int x, input bit g, input int gap);
    int junk;
    step(1'b1, g, 1'b1, x);
    for (int i = 0; i < gap; i++) begin
      junk = int'($urandom_range(0, 65535));
      step(1'b1, 1'b0, 1'b0, junk);
    end
  endtask

  task automatic check_reset();
    for (int k = 0; k < NI; k++) begin
      n_vec = n_vec + 1;
      if (ov[k] !== 1'b0 || od[k] !== '0 || odn[k] !== 1'b0) begin
        n_err = n_err + 1;
        $display("FAIL reset out%0d: got v=%0b d=%0d done=%0b, want v=0 d=0 done=0",
                 k, ov[k], $signed(od[k]), odn[k]);
      end
    end
  endtask

  initial begin
    int v;
    int win [4] = '{-3, -7, -1, -20};

    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    check_reset();
    mon_en = 1'b1;

    // Bypass sanity pair, then directed frames
    send(3, 1'b1, 0);
    send(-2, 1'b0, 0);
    for (int i = 0; i < 16; i++) send(i, i == 0, 0);
    for (int i = 0; i < 25; i++) send(i, i == 0, 0);
    for (int i = 0; i < 16; i++) begin
      v = -100;
      if (i == 0) v = win[0];
      if (i == 1) v = win[1];
      if (i == 4) v = win[2];
      if (i == 5) v = win[3];
      send(v, i == 0, 0);
    end
    for (int i = 0; i < 16; i++) send(i, i == 0, 1);

    // Abort after 6 samples with a restart carrying valid data
    for (int i = 0; i < 6; i++) send(100 + i, i == 0, 0);
    for (int i = 0; i < 16; i++) send(i, i == 0, 0);

    // Reset in the middle of a frame
    for (int i = 0; i < 7; i++) send(50 + i, i == 0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    check_reset();
    for (int i = 0; i < 16; i++) send(i, i == 0, 0);

    // Randomized frames with gaps and occasional stray restarts
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 30; i++) begin
        v = int'($signed(16'($urandom_range(0, 65535))));
        send(v, (i == 0) || ($urandom_range(0, 40) == 0),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
    end

    repeat (4) step(1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < NI; k++) begin
      if (q[k].size() != 0) begin
        n_vec = n_vec + 1;
        n_err = n_err + 1;
        $display("FAIL drain out%0d: got %0d outstanding expectations, want 0", k, q[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maxpool_stage.md
Name: maxpool_stage

Overview:
- Downstream neighbour of the convolution top block. Consumes the conv result stream: one sample per valid cycle, raster order, IN_SIZE x IN_SIZE per frame.
- Applies a 2x2, stride-2 signed max-pool and emits the pooled stream with a valid strobe, plus a one-cycle end-of-frame pulse.
- When MAXPOOL=0 it is a one-cycle registered pass-through.

Parameters:
- DATA_WIDTH, 16: signed sample width, in and out.
- IN_SIZE, 8: input frame side. Equals the conv OUT_SIZE and is set by the parent. Range 2..1024.
- MAXPOOL, 1: 1 = pool, 0 = bypass.
- POOL_SIZE (localparam), IN_SIZE/2 (floor): output frame side and line-buffer depth.

Ports:
- i_clk, in, 1: single clock. All logic on the rising edge.
- i_rst, in, 1: synchronous, active-low reset.
- i_go, in, 1: frame-start pulse. Clears the position counters.
- i_valid, in, 1: i_data is valid this cycle. No backpressure exists.
- i_data, in, DATA_WIDTH: signed conv result.
- o_valid, out, 1: o_data is valid. Single-cycle strobe per pooled sample.
- o_data, out, DATA_WIDTH: signed pooled sample (or bypassed sample).
- o_done, out, 1: one-cycle pulse at frame end.

Behaviour:
- Reset (i_rst=0 at a clock edge): o_valid=0, o_data=0, o_done=0, and col/row counters=0. Line buffer and hold register are not reset; they are always written before being read. Reset mid-frame discards the partial frame with no o_done.
- Counters: col 0..IN_SIZE-1 and row 0..IN_SIZE-1.
  - Advance only on i_valid. Gaps in i_valid are allowed and freeze all state.
  - col wraps to 0 and increments row. After (IN_SIZE-1, IN_SIZE-1) both wrap to 0.
- i_go: forces col=row=0.
  - If i_valid is high in the same cycle, that sample is processed as position (0,0).
  - i_go mid-frame aborts the frame: no o_done, and stale line-buffer contents are overwritten before use.
- Pool datapath (MAXPOOL=1), per accepted sample x at (row, col):
  - col even and col < 2*POOL_SIZE: hold <= x.
  - col odd: pm = smax(hold, x).
    - row even: lb[col>>1] <= pm.
    - row odd and row < 2*POOL_SIZE: o_data <= smax(lb[col>>1], pm), o_valid <= 1.
  - Odd IN_SIZE: the final column and final row are ignored (floor semantics).
  - smax is a signed two's-complement compare; ties return the common value.
  - No width growth; o_data is DATA_WIDTH.
- Latency: o_valid is high exactly one cycle after the accepting edge of the bottom-right sample of each 2x2 window. POOL_SIZE*POOL_SIZE strobes per frame, in raster order.
- o_done: high for one cycle, one cycle after the accepting edge of sample (IN_SIZE-1, IN_SIZE-1). For even IN_SIZE this coincides with the last o_valid.
- Bypass (MAXPOOL=0): o_data <= i_data and o_valid <= i_valid, one-cycle latency. Counters still run and o_done is generated identically.
- o_valid defaults to 0 in any cycle without a qualifying accept.

Decomposition:
- global.v:
  - add a `DATA_WIDTH define;
  - reuse `MAXPOOL;
  - IN_SIZE is derived in the parent from `FM_SIZE/`KERNEL_SIZE/`PADDING/`STRIDE.
- One sub-module: maxpool_line_buf, a POOL_SIZE x DATA_WIDTH register array with 1 write and 1 read port.
  - Combinational read, synchronous write.
  - Read-before-write is not required: reads occur only on odd rows and writes only on even rows.
- smax stays an inline function.

Test Plan:
- IN_SIZE=4, MAXPOOL=1, samples 0..15 with continuous i_valid -> o_data 5, 7, 13, 15. Each strobe one cycle after inputs 5, 7, 13, 15. o_done coincides with the final 15.
- IN_SIZE=5, samples 0..24 -> o_data 6, 8, 16, 18. o_done one cycle after sample 24. No output for column 4 or row 4.
- IN_SIZE=4, signed window {-3, -7, -1, -20} at (0..1, 0..1), all other samples -100 -> first output -1, remaining outputs -100.
- IN_SIZE=4, samples 0..15 with i_valid low on every other cycle -> same outputs 5, 7, 13, 15. Each o_valid is one cycle wide, and there are no extra strobes during gaps.
- i_go asserted with i_valid after 6 samples of a 4x4 frame, then a fresh 0..15 frame -> outputs 5, 7, 13, 15. Exactly one o_done.
- i_rst=0 for one cycle mid-frame -> outputs 0 the next cycle. A following full frame produces correct results. MAXPOOL=0 with samples 3, -2 -> o_data 3, -2 at one-cycle latency.
